// File: rtl/mastermind_ctrl.sv
// mastermind_ctrl: turn/score controller wrapped around a combinational 4-peg, 4-colour evaluator
//   clk, reset_n        clock, asynchronous active-low reset
//   load_secret         strobe: latch secret_in into eval_b and start a new game
//   guess_valid/ready   guess handshake; an accepted guess_in is latched into eval_a
//   eval_a, eval_b      registered guess/secret driven to the evaluator
//   c_in, m_in          evaluator exact / misplaced vectors
//   exact_cnt/near_cnt  popcounts of c_in/m_in for the last scored guess
//   result_valid        one-cycle pulse when counts and turn update
//   turn, win, lose     guesses used, game-over levels
//   guess_reject        duplicate-guess pulse, only with MM_DUPREJ_EN defined
module mastermind_ctrl #(
    parameter int MAX_TURNS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_secret,
    input  logic [7:0] secret_in,
    input  logic       guess_valid,
    input  logic [7:0] guess_in,
    output logic       guess_ready,
    output logic [7:0] eval_a,
    output logic [7:0] eval_b,
    input  logic [3:0] c_in,
    input  logic [3:0] m_in,
    output logic [2:0] exact_cnt,
    output logic [2:0] near_cnt,
    output logic       result_valid,
    output logic [3:0] turn,
    output logic       win,
    output logic       lose
`ifdef MM_DUPREJ_EN
    ,
    output logic       guess_reject
`endif
);
    typedef enum logic [2:0] {IDLE, READY, EVAL, WIN, LOSE} state_t;
    state_t state;
    logic dup;
    logic [3:0] turn_nx;
    logic [2:0] exact_nx;
    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction
    assign turn_nx     = turn + 4'd1;
    assign exact_nx    = pop4(c_in);
    assign guess_ready = (state == READY);
`ifdef MM_DUPREJ_EN
    // guess_reject is registered at acceptance and stays visible through the EVAL cycle,
    // where it diverts the FSM back to READY without scoring
    logic have_prev;
    assign dup = guess_reject;
`else
    assign dup = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            eval_a       <= '0;
            eval_b       <= '0;
            exact_cnt    <= '0;
            near_cnt     <= '0;
            result_valid <= 1'b0;
            turn         <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
`ifdef MM_DUPREJ_EN
            guess_reject <= 1'b0;
            have_prev    <= 1'b0;
`endif
        end else begin
            result_valid <= 1'b0;
`ifdef MM_DUPREJ_EN
            guess_reject <= 1'b0;
`endif
            if (load_secret) begin
                eval_b    <= secret_in;
                turn      <= '0;
                exact_cnt <= '0;
                near_cnt  <= '0;
                win       <= 1'b0;
                lose      <= 1'b0;
                state     <= READY;
`ifdef MM_DUPREJ_EN
                have_prev <= 1'b0;
`endif
            end else begin
                case (state)
                    READY: if (guess_valid) begin
                        eval_a <= guess_in;
                        state  <= EVAL;
`ifdef MM_DUPREJ_EN
                        guess_reject <= have_prev && (guess_in == eval_a);
                        have_prev    <= 1'b1;
`endif
                    end
                    EVAL: if (dup) begin
                        state <= READY;
                    end else begin
                        exact_cnt    <= exact_nx;
                        near_cnt     <= pop4(m_in);
                        turn         <= turn_nx;
                        result_valid <= 1'b1;
                        win          <= (exact_nx == 3'd4);
                        lose         <= (exact_nx != 3'd4) && (turn_nx == 4'(MAX_TURNS));
                        state        <= (exact_nx == 3'd4) ? WIN : (turn_nx == 4'(MAX_TURNS)) ? LOSE : READY;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mastermind_ctrl.sv
// tb_mastermind_ctrl: scoreboard bench for mastermind_ctrl with a behavioural peg evaluator
module tb_mastermind_ctrl;
    localparam int MT = 3;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       reset_n, load_secret, guess_valid;
    logic [7:0] secret_in, guess_in;
    logic       guess_ready, result_valid, win, lose;
    logic [7:0] eval_a, eval_b;
    logic [3:0] c_in, m_in, turn;
    logic [2:0] exact_cnt, near_cnt;
`ifdef MM_DUPREJ_EN
    logic       guess_reject;
`endif
    mastermind_ctrl #(.MAX_TURNS(MT)) dut (
        .clk(clk), .reset_n(reset_n), .load_secret(load_secret), .secret_in(secret_in),
        .guess_valid(guess_valid), .guess_in(guess_in), .guess_ready(guess_ready),
        .eval_a(eval_a), .eval_b(eval_b), .c_in(c_in), .m_in(m_in),
        .exact_cnt(exact_cnt), .near_cnt(near_cnt), .result_valid(result_valid),
        .turn(turn), .win(win), .lose(lose)
`ifdef MM_DUPREJ_EN
        , .guess_reject(guess_reject)
`endif
    );
    typedef struct {logic [2:0] e; logic [2:0] n; logic [3:0] t; logic w; logic l;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    logic [7:0] sec_m;
    logic [3:0] turn_m;
    // peg evaluator: exact vector, then greedy misplaced assignment per guess peg
    function automatic logic [7:0] evalv(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] c, m, used;
        logic done;
        c = '0; m = '0; used = '0;
        for (int i = 0; i < 4; i++) c[i] = (a[2*i +: 2] == b[2*i +: 2]);
        for (int i = 0; i < 4; i++) begin
            done = 1'b0;
            for (int j = 0; j < 4; j++)
                if (!c[i] && !done && !c[j] && !used[j] && a[2*i +: 2] == b[2*j +: 2]) begin
                    m[i] = 1'b1; used[j] = 1'b1; done = 1'b1;
                end
        end
        return {m, c};
    endfunction
    assign {m_in, c_in} = evalv(eval_a, eval_b);
    // reference score by colour histograms
    task automatic exp_score(input logic [7:0] g, input logic [7:0] s, output logic [2:0] e, output logic [2:0] n);
        int ga[4], sb[4];
        e = 0; n = 0;
        for (int k = 0; k < 4; k++) begin ga[k] = 0; sb[k] = 0; end
        for (int i = 0; i < 4; i++)
            if (g[2*i +: 2] == s[2*i +: 2]) e++;
            else begin ga[g[2*i +: 2]]++; sb[s[2*i +: 2]]++; end
        for (int k = 0; k < 4; k++) n += 3'(ga[k] < sb[k] ? ga[k] : sb[k]);
    endtask
    always @(negedge clk) begin
        exp_t x;
        if (reset_n && result_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result result_valid=1 with no result pending");
            end else begin
                x = q.pop_front();
                if ({exact_cnt, near_cnt, turn, win, lose} !== {x.e, x.n, x.t, x.w, x.l}) begin
                    errors++;
                    $display("FAIL result got e=%0d n=%0d t=%0d w=%b l=%b want e=%0d n=%0d t=%0d w=%b l=%b",
                             exact_cnt, near_cnt, turn, win, lose, x.e, x.n, x.t, x.w, x.l);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    // all tasks start and end on a falling edge
    task automatic do_load(input logic [7:0] s);
        load_secret = 1'b1; secret_in = s; sec_m = s; turn_m = 0;
        @(negedge clk);
        load_secret = 1'b0;
        checks++;
        if ({eval_b, turn, win, lose, exact_cnt, near_cnt, guess_ready} !== {s, 4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL load got b=%h t=%0d w=%b l=%b e=%0d n=%0d rdy=%b want b=%h t=0 w=0 l=0 e=0 n=0 rdy=1",
                     eval_b, turn, win, lose, exact_cnt, near_cnt, guess_ready, s);
        end
    endtask
    task automatic do_guess(input logic [7:0] g, input bit dup);
        logic [2:0] e, n;
        logic exp_rdy;
        exp_rdy = 1'b1;
        checks++;
        if (guess_ready !== 1'b1) begin errors++; $display("FAIL ready_pre got %b want 1", guess_ready); end
        guess_in = g; guess_valid = 1'b1;
        if (!dup) begin
            exp_score(g, sec_m, e, n);
            turn_m++;
            exp_rdy = !(e == 3'd4 || turn_m == 4'(MT));
            q.push_back('{e, n, turn_m, e == 3'd4, e != 3'd4 && turn_m == 4'(MT)});
        end
        @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || eval_a !== g || guess_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept got rv=%b a=%h rdy=%b want rv=0 a=%h rdy=0", result_valid, eval_a, guess_ready, g);
        end
`ifdef MM_DUPREJ_EN
        checks++;
        if (guess_reject !== dup) begin errors++; $display("FAIL reject got %b want %b", guess_reject, dup); end
`endif
        @(negedge clk);
        checks++;
        if (result_valid !== !dup || guess_ready !== exp_rdy) begin
            errors++;
            $display("FAIL latency got rv=%b rdy=%b want rv=%b rdy=%b", result_valid, guess_ready, !dup, exp_rdy);
        end
    endtask
    task automatic test_reset;
        reset_n = 1'b0; load_secret = 1'b0; guess_valid = 1'b0; secret_in = '0; guess_in = '0;
        sec_m = '0; turn_m = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({guess_ready, eval_a, eval_b, exact_cnt, near_cnt, result_valid, turn, win, lose} !== '0) begin
            errors++;
            $display("FAIL reset got rdy=%b a=%h b=%h e=%0d n=%0d rv=%b t=%0d w=%b l=%b want all 0",
                     guess_ready, eval_a, eval_b, exact_cnt, near_cnt, result_valid, turn, win, lose);
        end
        reset_n = 1'b1;
        guess_valid = 1'b1; guess_in = 8'h10;
        repeat (2) @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (eval_a !== 8'h00 || guess_ready !== 1'b0 || turn !== 4'd0) begin
            errors++;
            $display("FAIL idle_ignore got a=%h rdy=%b t=%0d want a=00 rdy=0 t=0", eval_a, guess_ready, turn);
        end
    endtask
    task automatic test_win;
        do_load(8'h04);
        do_guess(8'h04, 0);
        guess_valid = 1'b1; guess_in = 8'h10;
        repeat (2) @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (eval_a !== 8'h04 || turn !== 4'd1 || win !== 1'b1 || guess_ready !== 1'b0) begin
            errors++;
            $display("FAIL win_hold got a=%h t=%0d w=%b rdy=%b want a=04 t=1 w=1 rdy=0", eval_a, turn, win, guess_ready);
        end
    endtask
    task automatic test_partial;
        do_load(8'h04);
        do_guess(8'h10, 0);
        checks++;
        if (exact_cnt !== 3'd2 || near_cnt !== 3'd2) begin
            errors++;
            $display("FAIL partial got e=%0d n=%0d want e=2 n=2", exact_cnt, near_cnt);
        end
    endtask
    task automatic test_lose;
        do_load(8'h04);
        repeat (MT) do_guess(8'hFF, 0);
        guess_valid = 1'b1; guess_in = 8'h55;
        repeat (3) @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (turn !== 4'(MT) || lose !== 1'b1 || win !== 1'b0 || eval_a !== 8'hFF) begin
            errors++;
            $display("FAIL lose_hold got t=%0d l=%b w=%b a=%h want t=%0d l=1 w=0 a=ff", turn, lose, win, eval_a, MT);
        end
    endtask
    task automatic test_reset_eval;
        do_load(8'h04);
        guess_valid = 1'b1; guess_in = 8'h10;
        @(negedge clk);
        guess_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({guess_ready, eval_a, eval_b, exact_cnt, near_cnt, result_valid, turn, win, lose} !== '0) begin
            errors++;
            $display("FAIL reset_eval got rdy=%b a=%h b=%h e=%0d n=%0d rv=%b t=%0d want all 0",
                     guess_ready, eval_a, eval_b, exact_cnt, near_cnt, result_valid, turn);
        end
        @(negedge clk);
        reset_n = 1'b1;
        guess_valid = 1'b1; guess_in = 8'h04;
        repeat (3) @(negedge clk);
        guess_valid = 1'b0;
        checks++;
        if (guess_ready !== 1'b0 || eval_a !== 8'h00 || turn !== 4'd0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b a=%h t=%0d rv=%b want 0 00 0 0", guess_ready, eval_a, turn, result_valid);
        end
    endtask
    task automatic test_load_priority;
        do_load(8'h04);
        do_guess(8'h10, 0);
        load_secret = 1'b1; secret_in = 8'h1B; guess_valid = 1'b1; guess_in = 8'h27;
        @(negedge clk);
        load_secret = 1'b0; guess_valid = 1'b0;
        sec_m = 8'h1B; turn_m = 0;
        checks++;
        if (eval_b !== 8'h1B || eval_a !== 8'h10 || turn !== 4'd0 || guess_ready !== 1'b1 || exact_cnt !== 3'd0) begin
            errors++;
            $display("FAIL load_prio got b=%h a=%h t=%0d rdy=%b e=%0d want b=1b a=10 t=0 rdy=1 e=0",
                     eval_b, eval_a, turn, guess_ready, exact_cnt);
        end
        repeat (2) @(negedge clk);
        guess_valid = 1'b1; guess_in = 8'h1B;
        @(negedge clk);
        guess_valid = 1'b0; load_secret = 1'b1; secret_in = 8'h04;
        @(negedge clk);
        load_secret = 1'b0; sec_m = 8'h04;
        repeat (2) @(negedge clk);
        checks++;
        if (turn !== 4'd0 || win !== 1'b0 || guess_ready !== 1'b1 || eval_b !== 8'h04) begin
            errors++;
            $display("FAIL load_in_eval got t=%0d w=%b rdy=%b b=%h want t=0 w=0 rdy=1 b=04", turn, win, guess_ready, eval_b);
        end
    endtask
    task automatic test_back_to_back;
        do_load(8'h1B);
        do_guess(8'h00, 0);
        checks++;
        if (exact_cnt !== 3'd1 || near_cnt !== 3'd0) begin
            errors++;
            $display("FAIL b2b_first got e=%0d n=%0d want e=1 n=0", exact_cnt, near_cnt);
        end
        do_guess(8'hE4, 0);
        do_guess(8'h1B, 0);
    endtask
`ifdef MM_DUPREJ_EN
    task automatic test_dupreject;
        do_load(8'h04);
        do_guess(8'h10, 0);
        do_guess(8'h10, 1);
        checks++;
        if (turn !== 4'd1) begin errors++; $display("FAIL dup_turn got %0d want 1", turn); end
        do_guess(8'h04, 0);
    endtask
`endif
    initial begin
        test_reset();
        test_win();
        test_partial();
        test_lose();
        test_reset_eval();
        test_load_priority();
        test_back_to_back();
`ifdef MM_DUPREJ_EN
        test_dupreject();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL pending got %0d results outstanding want 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mastermind_ctrl.md
# mastermind_ctrl

Game controller for the 4-peg, 4-colour code-breaking game. It latches a secret code and accepts player guesses with a valid/ready handshake. It drives the combinational peg evaluator's `a` (guess) and `b` (secret) inputs and consumes its `c` (exact) and `m` (near) vectors. It also counts pegs, tracks turns and declares win/lose. It sits directly downstream of the evaluator and upstream of the display/HEX logic.

## Interface
- `MAX_TURNS`, 10: guesses allowed per game, range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_secret`  in  1  single-cycle strobe; latch `secret_in` and start a new game.
- `secret_in`  in  8  secret code, 4 pegs × 2 bits, peg0 = [1:0].
- `guess_valid`  in  1  a guess is presented on `guess_in`.
- `guess_in`  in  8  guess code, same packing as `secret_in`.
- `guess_ready`  out  1  controller can accept a guess.
- `eval_a`  out  8  registered guess, to evaluator `a`.
- `eval_b`  out  8  registered secret, to evaluator `b`.
- `c_in`  in  4  evaluator exact-match vector.
- `m_in`  in  4  evaluator misplaced vector.
- `exact_cnt`  out  3  popcount of `c_in` for the last guess, 0..4.
- `near_cnt`  out  3  popcount of `m_in` for the last guess, 0..4.
- `result_valid`  out  1  one-cycle pulse; counts updated this cycle.
- `turn`  out  4  guesses consumed in the current game.
- `win`  out  1  level; game won.
- `lose`  out  1  level; game lost.
- `guess_reject`  out  1  one-cycle pulse; present only when `MM_DUPREJ_EN` is defined.

## Operation
- The FSM has five states: IDLE, READY, EVAL, WIN and LOSE.
- On reset: state is IDLE. All outputs are 0, including `eval_a`, `eval_b`, counts, `turn`, `win`, `lose` and pulses.
- IDLE:
  - `guess_ready` = 0.
  - `load_secret` → latch `eval_b` ← `secret_in`, clear `turn`, counts, `win` and `lose`, go to READY.
- READY:
  - `guess_ready` = 1.
  - `guess_valid` (handshake) → `eval_a` ← `guess_in`, go to EVAL.
- EVAL:
  - `guess_ready` = 0.
  - Sample `c_in`/`m_in`, which are combinational from the registered `eval_a`/`eval_b`.
  - Register `exact_cnt` and `near_cnt`; `turn` ← `turn`+1; pulse `result_valid`.
  - Next state: exact = 4 → WIN; else new `turn` = `MAX_TURNS` → LOSE; else → READY.
- WIN/LOSE:
  - Hold `win` or `lose` = 1, plus the last counts and `turn`.
  - `guess_ready` = 0; `guess_valid` is ignored.
- `load_secret` in any state restarts the game exactly as from IDLE. It has priority over `guess_valid` in the same cycle. In EVAL it discards the pending result: no `result_valid`, `turn` goes to 0.
- Counts are pure popcounts of the evaluator vectors; the controller does no colour logic of its own.
- `turn` never exceeds `MAX_TURNS`. No wrap.
- `eval_b` changes only on `load_secret`. `eval_a` changes only on an accepted guess.

## Timing
- A guess accepted at edge N enters EVAL in cycle N+1. Results are registered at edge N+2.
- `result_valid`, new counts, new `turn` and `win`/`lose` are all visible in the same cycle, N+2. Accept-to-result latency is 2 cycles.
- `guess_ready` is high again in cycle N+2 when the next state is READY. Maximum throughput is one guess per 2 cycles.
- `win`/`lose` rise in the same cycle as the final `result_valid`.
- Asynchronous reset mid-EVAL aborts immediately. No `result_valid` is produced; the FSM returns to IDLE.

## Configuration
- `MM_DUPREJ_EN` defined:
  - An accepted guess equal to the previous accepted guess of the current game is rejected.
  - On rejection: `guess_reject` pulses one cycle after acceptance, the FSM returns to READY, and `turn`, counts and `result_valid` are unaffected.
  - The first guess after `load_secret` is never rejected.
- `MM_DUPREJ_EN` undefined: no compare logic, no `guess_reject` port. Duplicate guesses consume turns normally.

## Test plan
- Reset, then `load_secret` with 8'h04, then guess 8'h04 → `result_valid` at accept+2, `exact_cnt`=4, `near_cnt`=0, `turn`=1, `win`=1, `guess_ready`=0.
- Secret 8'h04, guess 8'h10 → `exact_cnt`=2, `near_cnt`=2, `turn`=1, back to READY (`guess_ready`=1).
- `MAX_TURNS`=3, secret 8'h04, three guesses of 8'hFF → `turn`=3 and `lose`=1 on the third result. A fourth `guess_valid` is ignored; `turn` stays 3.
- `reset_n` low during EVAL → no `result_valid`, all outputs 0 and state IDLE. `guess_valid` is ignored until `load_secret`.
- `load_secret` (8'h1B) and `guess_valid` in the same READY cycle → new secret latched, `turn`=0, guess dropped, no `result_valid`.
- `MM_DUPREJ_EN`: secret 8'h04, guess 8'h10 twice → second guess yields `guess_reject`=1, `turn` stays 1. Guess 8'h04 next → `win`=1, `turn`=2.
